// File: rtl/mem_block_responder.sv
// Main-memory responder for the data cache's block-transfer port.
// One 128-bit block read or write is accepted per request. The answer comes
// back as a one-cycle mem_ready pulse LATENCY edges after the request is
// captured. The 64-block array reloads a known image on reset. Traffic
// counters and a sticky protocol-error flag are provided for bring-up.
module mem_block_responder #(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned NBLK     = 64,
  parameter logic [7:0]  INIT_TAG = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   mem_req_addr,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  input  logic [127:0] mem_data_write,
  output logic [127:0] mem_data_read,
  output logic         mem_ready,
  output logic         busy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic         proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           capture, complete, abort;

  // Request fields frozen at capture. Later input changes have no effect.
  logic [5:0]     idx_q;
  logic           rw_q;
  logic [127:0]   wdata_q;

  logic [127:0]   mem [NBLK];

  // The low address bits select a word inside the block. Transfers always
  // move a whole block, so these bits are intentionally dropped.
  logic           addr_lo_unused;
  assign addr_lo_unused = ^mem_req_addr[1:0];

  // State and latency counter register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. In BUSY, cnt counts down from LATENCY-1. The
  // completing edge comes when the count is already zero. This places
  // ready exactly LATENCY edges after capture, and also covers LATENCY=1.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req_valid) begin
          capture   = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!mem_req_valid) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = RECOVER;
      RECOVER: if (!mem_req_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= mem_req_addr[7:2];
      rw_q    <= mem_req_rw;
      wdata_q <= mem_data_write;
    end
  end

  // Block array: reset image load and write commit on completion.
  // NOTE: this array is reset on purpose. The reset image is part of the
  // contract, so it is built from flops rather than inferred RAM, which
  // cannot be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBLK; b++) begin
        for (int w = 0; w < 4; w++) begin
          mem[b][w*32 +: 32] <= {INIT_TAG, 16'h0000, 6'(b), 2'(w)};
        end
      end
    end else if (complete && rw_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Registered response outputs, counters and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_read <= '0;
      mem_ready     <= 1'b0;
      busy          <= 1'b0;
      rd_count      <= '0;
      wr_count      <= '0;
      proto_err     <= 1'b0;
    end else begin
      mem_ready <= complete;
      busy      <= (state_nxt != IDLE);
      if (abort) proto_err <= 1'b1;
      if (complete) begin
        // A write echoes its own data so the initiator sees what landed.
        mem_data_read <= rw_q ? wdata_q : mem[idx_q];
        if (rw_q) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench for mem_block_responder. A reference block model
// produces the expected read data when a request is driven. That value is
// queued and compared when mem_ready pulses. A second instance built with
// LATENCY=1 checks the shortest response path.
module tb_mem_block_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;

  logic [7:0]   mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic [127:0] mem_data_write;
  logic [127:0] mem_data_read;
  logic         mem_ready;
  logic         busy;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic         proto_err;

  logic [7:0]   addr1;
  logic         rw1;
  logic         valid1;
  logic [127:0] wdata1;
  logic [127:0] rdata1;
  logic         ready1;
  logic         busy1;
  logic [15:0]  rd_count1;
  logic [15:0]  wr_count1;
  logic         proto_err1;

  int           n_tests = 0;
  int           n_fail  = 0;

  logic [127:0] model [64];
  logic [127:0] exp_q [$];
  int           exp_rd, exp_wr;

  always #5 clk = ~clk;

  mem_block_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_valid(mem_req_valid), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read), .mem_ready(mem_ready), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  mem_block_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .mem_req_addr(addr1), .mem_req_rw(rw1),
    .mem_req_valid(valid1), .mem_data_write(wdata1),
    .mem_data_read(rdata1), .mem_ready(ready1), .busy(busy1),
    .rd_count(rd_count1), .wr_count(wr_count1), .proto_err(proto_err1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_blk(input int b);
    logic [127:0] r;
    logic [5:0]   b6;
    b6 = b[5:0];
    for (int w = 0; w < 4; w++) begin
      logic [1:0] w2;
      w2 = w[1:0];
      r[w*32 +: 32] = {8'hA5, 16'h0000, b6, w2};
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 64; b++) model[b] = init_blk(b);
    exp_rd = 0;
    exp_wr = 0;
  endtask

  // Drive one request, expect ready LATENCY edges after capture. Then keep
  // valid high for 'hold' more edges before dropping it.
  task automatic do_req(input string tag, input logic [7:0] addr, input logic rw,
                        input logic [127:0] data, input int hold);
    int           n;
    logic         seen;
    logic [127:0] e;
    logic [5:0]   idx;
    idx = addr[7:2];
    if (rw) begin
      model[idx] = data;
      exp_q.push_back(data);
    end else begin
      exp_q.push_back(model[idx]);
    end
    mem_req_addr   = addr;
    mem_req_rw     = rw;
    mem_data_write = data;
    mem_req_valid  = 1'b1;
    @(posedge clk); #1;
    // Scramble the request fields after capture; they must be ignored.
    mem_req_addr   = ~addr;
    mem_req_rw     = ~rw;
    mem_data_write = ~data;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (mem_ready) seen = 1'b1;
    end
    check({tag, "_latency"}, 128'(n), 128'(LAT));
    e = exp_q.pop_front();
    if (seen) begin
      check({tag, "_data"}, mem_data_read, e);
      if (rw) exp_wr++;
      else    exp_rd++;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_single_ack"}, 128'(mem_ready), 128'(0));
    end
    check({tag, "_rd_count"}, 128'(rd_count), 128'(exp_rd));
    check({tag, "_wr_count"}, 128'(wr_count), 128'(exp_wr));
    mem_req_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    rst            = 1'b0;
    mem_req_addr   = '0;
    mem_req_rw     = 1'b0;
    mem_req_valid  = 1'b0;
    mem_data_write = '0;
    addr1          = '0;
    rw1            = 1'b0;
    valid1         = 1'b0;
    wdata1         = '0;
    model_reset();

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(mem_ready), 128'(0));
    check("rst_busy",  128'(busy), 128'(0));
    check("rst_data",  mem_data_read, 128'(0));
    check("rst_cnts",  128'({rd_count, wr_count}), 128'(0));
    check("rst_perr",  128'(proto_err), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset image read of block 5.
    do_req("reset_read", 8'h14, 1'b0, '0, 1);
    check("reset_read_const", mem_data_read,
          {32'hA5000017, 32'hA5000016, 32'hA5000015, 32'hA5000014});

    // Write then read the same block through a different low address.
    do_req("wr3c", 8'h3C, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1);
    do_req("rd3d", 8'h3D, 1'b0, '0, 1);

    // Cache-miss pair: write-back, then allocate to another block.
    do_req("wb20",  8'h20, 1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1);
    do_req("alcA0", 8'hA0, 1'b0, '0, 1);
    do_req("rd20",  8'h20, 1'b0, '0, 1);
    check("miss_perr", 128'(proto_err), 128'(0));

    // Valid held for three cycles after ready.
    do_req("hold3", 8'h44, 1'b0, '0, 3);

    // Valid dropped at the second BUSY edge.
    mem_req_addr   = 8'h1C;
    mem_req_rw     = 1'b1;
    mem_data_write = {4{32'hCAFE_F00D}};
    mem_req_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    stray = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      stray |= mem_ready;
    end
    check("abort_no_ready", 128'(stray), 128'(0));
    check("abort_perr",     128'(proto_err), 128'(1));
    check("abort_idle",     128'(busy), 128'(0));
    check("abort_wr_count", 128'(wr_count), 128'(exp_wr));
    do_req("abort_rd1c", 8'h1C, 1'b0, '0, 1);
    check("perr_sticky", 128'(proto_err), 128'(1));

    // Reset in the middle of a write.
    do_req("pre_wr24", 8'h24, 1'b1, {4{32'h5555_AAAA}}, 1);
    mem_req_addr   = 8'h24;
    mem_req_rw     = 1'b1;
    mem_data_write = {4{32'h1357_9BDF}};
    mem_req_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst           = 1'b1;
    mem_req_valid = 1'b0;
    #1;
    check("midrst_ready", 128'(mem_ready), 128'(0));
    check("midrst_cnts",  128'({rd_count, wr_count}), 128'(0));
    check("midrst_perr",  128'(proto_err), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    stray = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      stray |= mem_ready;
    end
    check("midrst_no_ready", 128'(stray), 128'(0));
    do_req("midrst_rd24", 8'h24, 1'b0, '0, 1);

    // LATENCY=1 instance: ready on the cycle after capture.
    addr1  = 8'h0C;
    rw1    = 1'b0;
    valid1 = 1'b1;
    @(posedge clk); #1;
    check("lat1_not_yet", 128'(ready1), 128'(0));
    @(posedge clk); #1;
    check("lat1_ready", 128'(ready1), 128'(1));
    check("lat1_data",  rdata1, init_blk(3));
    @(posedge clk); #1;
    check("lat1_single_ack", 128'(ready1), 128'(0));
    valid1 = 1'b0;
    @(posedge clk); #1;
    check("lat1_rd_count", 128'(rd_count1), 128'(1));
    check("lat1_idle",     128'(busy1), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
